// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared types, width limits and helpers for the UART TX arbiter.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef logic [2:0] width_t;

  localparam width_t WIDTH_MIN = 3'd1;
  localparam width_t WIDTH_MAX = 3'd4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic logic width_legal(input width_t w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter_if                                                   |
// | Requester handshake, FIFO write port and status of the TX arbiter.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_BYTES = 16
);
  localparam int CNT_W = $clog2(FIFO_BYTES + 1);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][31:0] req_data;
  logic [NUM_REQ-1:0][2:0]  req_width;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_write_enable;
  logic [31:0]              fifo_write_data;
  logic [2:0]               fifo_write_width;
  logic                     fifo_ack;
  logic [CNT_W-1:0]         fifo_level;
  logic [IDX_W-1:0]         grant_id;
  logic                     err_o;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, req_width, req_last, fifo_ack,
    output req_ready, fifo_write_enable, fifo_write_data, fifo_write_width,
    output fifo_level, grant_id, err_o
  );

  // Requester / FIFO side
  modport master (
    output req_valid, req_data, req_width, req_last, fifo_ack,
    input  req_ready, fifo_write_enable, fifo_write_data, fifo_write_width,
    input  fifo_level, grant_id, err_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick                                                              |
// | Combinational round-robin picker: first valid at or after ptr_i.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   index_o,
  output logic [NUM_REQ-1:0] onehot_o
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    found_o  = 1'b0;
    index_o  = '0;
    onehot_o = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(ptr_i) + k) % NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!found_o && valid_i[cand_idx]) begin
        found_o            = 1'b1;
        index_o            = cand_idx;
        onehot_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter                                                      |
// | Round-robin, packet-locking arbiter in front of a shared TX FIFO.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_BYTES = 16
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  uart_tx_arbiter_if.slave    bus
);

  localparam int CNT_W = $clog2(FIFO_BYTES + 1);
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e       state_q,    state_d;
  logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0] level_q,    level_d;
  logic             wen_q,      wen_d;
  logic [31:0]      wdata_q,    wdata_d;
  width_t           wwidth_q,   wwidth_d;
  logic             err_q,      err_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_REQ-1:0] sel_onehot;
  width_t             sel_width;
  logic               sel_legal;
  logic               sel_fits;
  logic [CNT_W-1:0]   free_bytes;
  logic [NUM_REQ-1:0] ready;
  logic               xfer;
  logic [CNT_W-1:0]   add_bytes;
  logic [CNT_W-1:0]   sub_bytes;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .valid_i  (bus.req_valid),
    .ptr_i    (rr_ptr_q),
    .found_o  (pick_found),
    .index_o  (pick_idx),
    .onehot_o (pick_onehot)
  );

  // Only the selected requester's width matters; all other readies are masked.
  always_comb begin
    sel_onehot = '0;
    if (state_q == LOCKED) begin
      sel_idx             = grant_id_q;
      sel_onehot[sel_idx] = 1'b1;
    end else begin
      sel_idx = pick_idx;
      if (pick_found) sel_onehot = pick_onehot;
    end
    sel_width  = bus.req_width[sel_idx];
    sel_legal  = width_legal(sel_width);
    free_bytes = CNT_W'(FIFO_BYTES) - level_q;
    sel_fits   = 32'(sel_width) <= 32'(free_bytes);
    ready      = sel_onehot & bus.req_valid
               & {NUM_REQ{reset_ni && (!sel_legal || sel_fits)}};
    xfer       = |ready;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    wen_d      = 1'b0;
    wdata_d    = wdata_q;
    wwidth_d   = wwidth_q;
    err_d      = 1'b0;
    add_bytes  = '0;
    sub_bytes  = '0;
    if (xfer) begin
      grant_id_d = sel_idx;
      if (sel_legal) begin
        wen_d     = 1'b1;
        wdata_d   = bus.req_data[sel_idx];
        wwidth_d  = sel_width;
        add_bytes = CNT_W'(sel_width);
      end else begin
        err_d = 1'b1;
      end
      if (bus.req_last[sel_idx]) begin
        state_d  = IDLE;
        rr_ptr_d = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
      end else begin
        state_d = LOCKED;
      end
    end
    // Credit is reserved at accept; an ack on an empty FIFO is spurious.
    if (bus.fifo_ack && (level_q != '0)) sub_bytes = CNT_W'(1);
    level_d = level_q + add_bytes - sub_bytes;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      level_q    <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wwidth_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      level_q    <= level_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wwidth_q   <= wwidth_d;
      err_q      <= err_d;
    end
  end

  assign bus.req_ready         = ready;
  assign bus.fifo_write_enable = wen_q;
  assign bus.fifo_write_data   = wdata_q;
  assign bus.fifo_write_width  = wwidth_q;
  assign bus.fifo_level        = level_q;
  assign bus.grant_id          = grant_id_q;
  assign bus.err_o             = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arbiter                                                   |
// | Directed self-checking bench for uart_tx_arbiter.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int FIFO_BYTES = 16;

  logic clk_i    = 1'b0;
  logic reset_ni = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_BYTES(FIFO_BYTES)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_BYTES(FIFO_BYTES)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_width = '0;
    bus.req_last  = '0;
    bus.fifo_ack  = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [2:0] w, input logic l);
    bus.req_valid[i] = 1'b1;
    bus.req_data[i]  = d;
    bus.req_width[i] = w;
    bus.req_last[i]  = l;
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_ni = 1'b1;
  endtask

  initial begin
    clear_inputs();

    // Reset values, readies held low while in reset even with valids up
    reset_ni = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_width = {4{3'd1}};
    tick();
    check_eq("rst_ready", bus.req_ready, 0);
    check_eq("rst_wen", bus.fifo_write_enable, 0);
    check_eq("rst_wdata", bus.fifo_write_data, 0);
    check_eq("rst_wwidth", bus.fifo_write_width, 0);
    check_eq("rst_level", bus.fifo_level, 0);
    check_eq("rst_grant", bus.grant_id, 0);
    check_eq("rst_err", bus.err_o, 0);
    do_reset();
    bus.fifo_ack = 1'b1;
    tick();
    check_eq("ack_at_zero_level", bus.fifo_level, 0);
    bus.fifo_ack = 1'b0;

    // Single beat
    do_reset();
    set_req(0, 32'hDEADBEEF, 3'd4, 1'b1);
    #1;
    check_eq("single_ready", bus.req_ready, 32'h1);
    tick();
    bus.req_valid = '0;
    check_eq("single_wen", bus.fifo_write_enable, 1);
    check_eq("single_wdata", bus.fifo_write_data, 32'hDEADBEEF);
    check_eq("single_wwidth", bus.fifo_write_width, 4);
    check_eq("single_level", bus.fifo_level, 4);
    check_eq("single_grant", bus.grant_id, 0);
    tick();
    check_eq("single_wen_drop", bus.fifo_write_enable, 0);

    // Round robin, all requesters held valid with single-byte closing beats
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h1000 + i, 3'd1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      #1;
      check_eq("rr_ready", bus.req_ready, 32'(1) << (k % 4));
      tick();
      check_eq("rr_grant", bus.grant_id, k % 4);
      check_eq("rr_level", bus.fifo_level, k + 1);
      check_eq("rr_wdata", bus.fifo_write_data, 32'h1000 + (k % 4));
    end

    // Locking: move rr_ptr to 1, then req1 sends 2,3,1 with req0/req2 waiting
    do_reset();
    set_req(0, 32'h0A, 3'd1, 1'b1);
    tick();
    set_req(1, 32'h1111, 3'd2, 1'b0);
    set_req(2, 32'h2222, 3'd1, 1'b1);
    #1;
    check_eq("lock_b1_ready", bus.req_ready, 32'b0010);
    tick();
    check_eq("lock_b1_grant", bus.grant_id, 1);
    check_eq("lock_b1_level", bus.fifo_level, 3);
    check_eq("lock_b1_wwidth", bus.fifo_write_width, 2);
    bus.req_valid[1] = 1'b0;
    #1;
    check_eq("lock_stall_ready", bus.req_ready, 0);
    tick();
    check_eq("lock_stall_wen", bus.fifo_write_enable, 0);
    set_req(1, 32'h3333, 3'd3, 1'b0);
    #1;
    check_eq("lock_b2_ready", bus.req_ready, 32'b0010);
    tick();
    check_eq("lock_b2_level", bus.fifo_level, 6);
    check_eq("lock_b2_wdata", bus.fifo_write_data, 32'h3333);
    set_req(1, 32'h4444, 3'd1, 1'b1);
    #1;
    check_eq("lock_b3_ready", bus.req_ready, 32'b0010);
    tick();
    check_eq("lock_b3_level", bus.fifo_level, 7);
    bus.req_valid[1] = 1'b0;
    #1;
    check_eq("lock_next_ready", bus.req_ready, 32'b0100);
    tick();
    check_eq("lock_next_grant", bus.grant_id, 2);
    check_eq("lock_next_level", bus.fifo_level, 8);
    bus.req_valid[2] = 1'b0;
    #1;
    check_eq("lock_wrap_ready", bus.req_ready, 32'b0001);
    tick();
    check_eq("lock_wrap_grant", bus.grant_id, 0);
    check_eq("lock_wrap_level", bus.fifo_level, 9);

    // Backpressure near full
    do_reset();
    set_req(0, 32'h55, 3'd4, 1'b1);
    tick();
    tick();
    tick();
    bus.req_width[0] = 3'd2;
    tick();
    check_eq("bp_fill_level", bus.fifo_level, 14);
    bus.req_width[0] = 3'd4;
    #1;
    check_eq("bp_full_ready", bus.req_ready, 0);
    tick();
    check_eq("bp_hold_level", bus.fifo_level, 14);
    check_eq("bp_hold_wen", bus.fifo_write_enable, 0);
    bus.fifo_ack = 1'b1;
    tick();
    check_eq("bp_ack1_level", bus.fifo_level, 13);
    check_eq("bp_ack1_ready", bus.req_ready, 0);
    tick();
    check_eq("bp_ack2_level", bus.fifo_level, 12);
    check_eq("bp_fit_ready", bus.req_ready, 32'b0001);
    tick();
    check_eq("bp_acc_ack_level", bus.fifo_level, 15);
    check_eq("bp_acc_ack_wen", bus.fifo_write_enable, 1);
    clear_inputs();

    // Illegal width: consumed, no write, one-cycle error pulse
    do_reset();
    set_req(3, 32'hBAD, 3'd0, 1'b1);
    #1;
    check_eq("ill_ready", bus.req_ready, 32'b1000);
    tick();
    bus.req_valid = '0;
    check_eq("ill_wen", bus.fifo_write_enable, 0);
    check_eq("ill_err", bus.err_o, 1);
    check_eq("ill_level", bus.fifo_level, 0);
    check_eq("ill_grant", bus.grant_id, 3);
    set_req(0, 32'h1, 3'd1, 1'b1);
    set_req(1, 32'h2, 3'd1, 1'b1);
    #1;
    check_eq("ill_rrptr_ready", bus.req_ready, 32'b0001);
    tick();
    check_eq("ill_err_clear", bus.err_o, 0);
    clear_inputs();
    set_req(2, 32'h7, 3'd7, 1'b1);
    tick();
    check_eq("ill7_err", bus.err_o, 1);
    check_eq("ill7_wen", bus.fifo_write_enable, 0);
    clear_inputs();

    // Asynchronous reset in the middle of a locked packet at level 9
    do_reset();
    set_req(2, 32'h99, 3'd4, 1'b0);
    tick();
    tick();
    bus.req_width[2] = 3'd1;
    tick();
    check_eq("mid_level", bus.fifo_level, 9);
    check_eq("mid_grant", bus.grant_id, 2);
    #2;
    reset_ni = 1'b0;
    #1;
    check_eq("async_level", bus.fifo_level, 0);
    check_eq("async_grant", bus.grant_id, 0);
    check_eq("async_wen", bus.fifo_write_enable, 0);
    check_eq("async_wdata", bus.fifo_write_data, 0);
    check_eq("async_ready", bus.req_ready, 0);
    tick();
    clear_inputs();
    reset_ni = 1'b1;
    set_req(0, 32'hA0, 3'd1, 1'b1);
    set_req(2, 32'hA2, 3'd1, 1'b1);
    #1;
    check_eq("post_rst_ready", bus.req_ready, 32'b0001);
    tick();
    check_eq("post_rst_grant", bus.grant_id, 0);
    check_eq("post_rst_level", bus.fifo_level, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
